// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: request types and the
// registered response-select field.
package mem_port_arbiter_pkg;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_I    = 2'd1,
    RESP_D    = 2'd2
  } resp_sel_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. req[0]/gnt[0] is the low requester and
// req[1]/gnt[1] is the high one. prio = 1 favours req[1] on a conflict.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | ~prio);
  assign gnt[1] = req[1] & (~req[0] |  prio);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data
// access. The response is registered one cycle after grant, and a
// saturating counter tracks how many cycles both sides collided.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter logic        RST_PRIO_D = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imemreq_val,
  output logic             imemreq_rdy,
  input  logic [31:0]      imemreq_addr,
  output logic             imemresp_val,
  output logic [31:0]      imemresp_data,
  input  logic             dmemreq_val,
  output logic             dmemreq_rdy,
  input  logic             dmemreq_type,
  input  logic [31:0]      dmemreq_addr,
  input  logic [31:0]      dmemreq_wdata,
  output logic             dmemresp_val,
  output logic [31:0]      dmemresp_rdata,
  output logic             memreq_val,
  output logic             memreq_type,
  output logic [31:0]      memreq_addr,
  output logic [31:0]      memreq_wdata,
  input  logic [31:0]      memresp_rdata,
  output logic [CNT_W-1:0] conflict_count
);

  logic             prio_q, prio_d;
  resp_sel_e        resp_sel_q, resp_sel_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] req, gnt;
  logic       conflict;

  // Gating the requests keeps every grant, and therefore every memory
  // write, suppressed while reset is held.
  assign req      = {dmemreq_val, imemreq_val} & {2{~rst}};
  assign conflict = imemreq_val & dmemreq_val;

  rr_arb2 u_rr (
    .req  (req),
    .prio (prio_q),
    .gnt  (gnt)
  );

  assign imemreq_rdy = gnt[0];
  assign dmemreq_rdy = gnt[1];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and a latch can never be inferred.
    memreq_val   = 1'b0;
    memreq_type  = MEM_RD;
    memreq_addr  = '0;
    memreq_wdata = '0;
    resp_sel_d   = RESP_NONE;
    resp_data_d  = '0;
    prio_d       = prio_q;
    cnt_d        = cnt_q;

    if (gnt[1]) begin
      memreq_val   = 1'b1;
      memreq_type  = dmemreq_type;
      memreq_addr  = dmemreq_addr;
      memreq_wdata = dmemreq_wdata;
      resp_sel_d   = RESP_D;
      resp_data_d  = (dmemreq_type == MEM_WR) ? '0 : memresp_rdata;
    end else if (gnt[0]) begin
      memreq_val   = 1'b1;
      memreq_addr  = imemreq_addr;
      resp_sel_d   = RESP_I;
      resp_data_d  = memresp_rdata;
    end

    // The conflict winner loses the next conflict.
    if (conflict) begin
      prio_d = gnt[0];
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= RST_PRIO_D;
      resp_sel_q  <= RESP_NONE;
      resp_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      prio_q      <= prio_d;
      resp_sel_q  <= resp_sel_d;
      resp_data_q <= resp_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign imemresp_val   = (resp_sel_q == RESP_I);
  assign dmemresp_val   = (resp_sel_q == RESP_D);
  assign imemresp_data  = imemresp_val ? resp_data_q : '0;
  assign dmemresp_rdata = dmemresp_val ? resp_data_q : '0;
  assign conflict_count = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-ported
// memory. A second instance with a 2-bit counter exercises saturation.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemreq_val, dmemreq_val, dmemreq_type;
  logic [31:0] imemreq_addr, dmemreq_addr, dmemreq_wdata;
  logic        imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val;
  logic [31:0] imemresp_data, dmemresp_rdata;
  logic        memreq_val, memreq_type;
  logic [31:0] memreq_addr, memreq_wdata, memresp_rdata;
  logic [15:0] conflict_count;

  logic        s_irdy, s_drdy, s_iresp_val, s_dresp_val, s_mval, s_mtype;
  logic [31:0] s_idata, s_drdata, s_maddr, s_mwdata;
  logic [1:0]  s_count;

  logic [31:0] mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.CNT_W(16), .RST_PRIO_D(1'b1)) dut (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_addr(imemreq_addr),
    .imemresp_val(imemresp_val), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_type(dmemreq_type),
    .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
    .dmemresp_val(dmemresp_val), .dmemresp_rdata(dmemresp_rdata),
    .memreq_val(memreq_val), .memreq_type(memreq_type), .memreq_addr(memreq_addr),
    .memreq_wdata(memreq_wdata), .memresp_rdata(memresp_rdata),
    .conflict_count(conflict_count)
  );

  mem_port_arbiter #(.CNT_W(2), .RST_PRIO_D(1'b1)) u_sat (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_rdy(s_irdy), .imemreq_addr(imemreq_addr),
    .imemresp_val(s_iresp_val), .imemresp_data(s_idata),
    .dmemreq_val(dmemreq_val), .dmemreq_rdy(s_drdy), .dmemreq_type(dmemreq_type),
    .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
    .dmemresp_val(s_dresp_val), .dmemresp_rdata(s_drdata),
    .memreq_val(s_mval), .memreq_type(s_mtype), .memreq_addr(s_maddr),
    .memreq_wdata(s_mwdata), .memresp_rdata(memresp_rdata),
    .conflict_count(s_count)
  );

  // Memory: combinational read, write committed at the clock edge.
  assign memresp_rdata = mem[memreq_addr[5:2]];
  always @(posedge clk)
    if (memreq_val && memreq_type) mem[memreq_addr[5:2]] <= memreq_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imemreq_val   = 1'b0;
    imemreq_addr  = 32'h0;
    dmemreq_val   = 1'b0;
    dmemreq_type  = 1'b0;
    dmemreq_addr  = 32'h0;
    dmemreq_wdata = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_memreq_val", {31'h0, memreq_val}, 32'h0);
      check("idle_iresp_val", {31'h0, imemresp_val}, 32'h0);
      check("idle_dresp_val", {31'h0, dmemresp_val}, 32'h0);
      check("idle_count", {16'h0, conflict_count}, 32'h0);
    end

    // Lone dmem write, then fetch of the same word
    dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h8; dmemreq_wdata = 32'h42;
    #1;
    check("wr_drdy", {31'h0, dmemreq_rdy}, 32'h1);
    check("wr_irdy", {31'h0, imemreq_rdy}, 32'h0);
    check("wr_mtype", {31'h0, memreq_type}, 32'h1);
    check("wr_maddr", memreq_addr, 32'h8);
    check("wr_mwdata", memreq_wdata, 32'h42);
    tick();
    check("wr_ack_val", {31'h0, dmemresp_val}, 32'h1);
    check("wr_ack_rdata", dmemresp_rdata, 32'h0);
    check("wr_ack_ival", {31'h0, imemresp_val}, 32'h0);
    idle_inputs();
    imemreq_val = 1'b1; imemreq_addr = 32'h8; dmemreq_wdata = 32'hFFFF_FFFF;
    #1;
    check("if_irdy", {31'h0, imemreq_rdy}, 32'h1);
    check("if_mtype", {31'h0, memreq_type}, 32'h0);
    check("if_mwdata", memreq_wdata, 32'h0);
    tick();
    check("if_val", {31'h0, imemresp_val}, 32'h1);
    check("if_data", imemresp_data, 32'h42);
    check("if_dval", {31'h0, dmemresp_val}, 32'h0);

    // Four conflict cycles: grants D, I, D, I
    idle_inputs();
    imemreq_val = 1'b1; imemreq_addr = 32'h4;
    dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'hC;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_drdy", {31'h0, dmemreq_rdy}, (k % 2 == 0) ? 32'h1 : 32'h0);
      check("rr_irdy", {31'h0, imemreq_rdy}, (k % 2 == 1) ? 32'h1 : 32'h0);
      tick();
      check("rr_dval", {31'h0, dmemresp_val}, (k % 2 == 0) ? 32'h1 : 32'h0);
      check("rr_ival", {31'h0, imemresp_val}, (k % 2 == 1) ? 32'h1 : 32'h0);
      check("rr_ddata", dmemresp_rdata, (k % 2 == 0) ? 32'hA000_0003 : 32'h0);
      check("rr_idata", imemresp_data, (k % 2 == 1) ? 32'hA000_0001 : 32'h0);
    end
    check("rr_count", {16'h0, conflict_count}, 32'd4);

    // Write then read the same address back to back
    idle_inputs();
    dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h0; dmemreq_wdata = 32'h13;
    tick();
    check("wtr_ack", {31'h0, dmemresp_val}, 32'h1);
    dmemreq_type = 1'b0; dmemreq_wdata = 32'h0;
    tick();
    check("wtr_val", {31'h0, dmemresp_val}, 32'h1);
    check("wtr_data", dmemresp_rdata, 32'h13);

    // One conflict to move the pointer to imem, then reset over a write
    imemreq_val = 1'b1; imemreq_addr = 32'h4;
    dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'hC;
    #1;
    check("pre_rst_drdy", {31'h0, dmemreq_rdy}, 32'h1);
    tick();
    check("pre_rst_count", {16'h0, conflict_count}, 32'd5);
    idle_inputs();
    dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h10; dmemreq_wdata = 32'hDEAD_BEEF;
    rst = 1'b1;
    #1;
    check("rst_drdy", {31'h0, dmemreq_rdy}, 32'h0);
    check("rst_mval", {31'h0, memreq_val}, 32'h0);
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    check("rst_mem", mem[4], 32'hA000_0004);
    check("rst_dval", {31'h0, dmemresp_val}, 32'h0);
    check("rst_ival", {31'h0, imemresp_val}, 32'h0);
    check("rst_count", {16'h0, conflict_count}, 32'h0);

    // Six conflicts: pointer restored to dmem first; small counter saturates
    imemreq_val = 1'b1; imemreq_addr = 32'h4;
    dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'hC;
    #1;
    check("post_rst_drdy", {31'h0, dmemreq_rdy}, 32'h1);
    check("post_rst_irdy", {31'h0, imemreq_rdy}, 32'h0);
    for (int k = 0; k < 6; k++) tick();
    check("sat_small", {30'h0, s_count}, 32'd3);
    check("sat_main", {16'h0, conflict_count}, 32'd6);
    idle_inputs();
    tick();
    check("sat_hold", {30'h0, s_count}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
